control_sequencer: RTL and testbench

Instruction sequencer for the 4-bit microcontroller. It fetches 8-bit instructions through a valid-qualified fetch handshake and steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK. It drives the 16-bit one-hot control bus that gates every datapath register load and ALU operation. It also owns the program counter.

---
 rtl/control_sequencer_pkg.sv | 42 ++++
 rtl/instr_decoder.sv | 35 +++
 rtl/control_sequencer.sv | 61 ++++++
 tb/tb_control_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared state encodings, opcodes and control bit indices for the sequencer, decoder and datapath
package control_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam int CTL_IR_LOAD  = 0;
  localparam int CTL_PC_INC   = 1;
  localparam int CTL_PC_LOAD  = 2;
  localparam int CTL_A_LOAD   = 3;
  localparam int CTL_B_LOAD   = 4;
  localparam int CTL_ACC_LOAD = 5;
  localparam int CTL_OUT_LOAD = 6;
  localparam int CTL_ALU_ADD  = 7;
  localparam int CTL_ALU_SUB  = 8;
  localparam int CTL_ALU_AND  = 9;
  localparam int CTL_ALU_OR   = 10;
  localparam int CTL_ALU_XOR  = 11;
  localparam int CTL_ALU_NOT  = 12;
  localparam int CTL_HALT     = 14;
  function automatic logic is_alu(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_NOT;
  endfunction
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational opcode/state to one-hot control word; in opcode,state,zero_flag,carry_flag; out control,needs_wb
module instr_decoder
  import control_sequencer_pkg::*;
(
  input  logic [3:0]  opcode,
  input  state_t      state,
  input  logic        zero_flag,
  input  logic        carry_flag,
  output logic [15:0] control,
  output logic        needs_wb
);
  always_comb begin
    control = '0;
    needs_wb = is_alu(opcode);
    if (state == S_DECODE) control[CTL_PC_INC] = 1'b1;
    else if (state == S_WRITEBACK) control[CTL_ACC_LOAD] = 1'b1;
    else if (state == S_EXECUTE)
      case (opcode)
        OP_LDA: control[CTL_A_LOAD] = 1'b1;
        OP_LDB: control[CTL_B_LOAD] = 1'b1;
        OP_ADD: control[CTL_ALU_ADD] = 1'b1;
        OP_SUB: control[CTL_ALU_SUB] = 1'b1;
        OP_AND: control[CTL_ALU_AND] = 1'b1;
        OP_OR:  control[CTL_ALU_OR] = 1'b1;
        OP_XOR: control[CTL_ALU_XOR] = 1'b1;
        OP_NOT: control[CTL_ALU_NOT] = 1'b1;
        OP_OUT: control[CTL_OUT_LOAD] = 1'b1;
        OP_JMP: control[CTL_PC_LOAD] = 1'b1;
        OP_JZ:  control[CTL_PC_LOAD] = zero_flag;
        OP_JC:  control[CTL_PC_LOAD] = carry_flag;
        OP_HLT: control[CTL_HALT] = 1'b1;
        default: control = '0;
      endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute/writeback FSM owning pc and IR; in clk,reset(active-low),run,instr,instr_valid,zero_flag,carry_flag; out fetch_req,pc,operand,alu_op,control,busy,halted
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [7:0]          instr,
  input  logic                instr_valid,
  input  logic                zero_flag,
  input  logic                carry_flag,
  output logic                fetch_req,
  output logic [PC_WIDTH-1:0] pc,
  output logic [3:0]          operand,
  output logic [3:0]          alu_op,
  output logic [15:0]         control,
  output logic                busy,
  output logic                halted
);
  state_t state, state_next;
  logic [7:0] ir;
  logic [15:0] dec_ctl;
  logic needs_wb;
  instr_decoder u_dec (
    .opcode    (ir[7:4]),
    .state     (state),
    .zero_flag (zero_flag),
    .carry_flag(carry_flag),
    .control   (dec_ctl),
    .needs_wb  (needs_wb)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state <= S_IDLE;
      pc <= '0;
      ir <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && instr_valid) ir <= instr;
      pc <= dec_ctl[CTL_PC_INC] ? pc + PC_WIDTH'(1) : dec_ctl[CTL_PC_LOAD] ? PC_WIDTH'(ir[3:0]) : pc;
    end
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      state_next = run ? S_FETCH : S_IDLE;
      S_FETCH:     state_next = instr_valid ? S_DECODE : S_FETCH;
      S_DECODE:    state_next = S_EXECUTE;
      S_EXECUTE:   state_next = ir[7:4] == OP_HLT ? S_HALT : needs_wb ? S_WRITEBACK : run ? S_FETCH : S_IDLE;
      S_WRITEBACK: state_next = run ? S_FETCH : S_IDLE;
      default:     state_next = state;
    endcase
    control = !reset ? '0 : state == S_FETCH ? {15'b0, instr_valid} : dec_ctl;
    fetch_req = reset && state == S_FETCH;
  end
  assign operand = ir[3:0];
  assign alu_op = ir[7:4];
  assign busy = state != S_IDLE && state != S_HALT;
  assign halted = state == S_HALT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed literal checks plus randomized run against an instruction-level reference model
module tb_control_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  logic [7:0] instr = '0;
  logic instr_valid = 1'b0;
  logic zero_flag = 1'b0;
  logic carry_flag = 1'b0;
  logic fetch_req;
  logic [3:0] pc;
  logic [3:0] operand;
  logic [3:0] alu_op;
  logic [15:0] control;
  logic busy;
  logic halted;
  int n_cmp = 0;
  int n_bad = 0;
  control_sequencer #(.PC_WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instr      (instr),
    .instr_valid(instr_valid),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .fetch_req  (fetch_req),
    .pc         (pc),
    .operand    (operand),
    .alu_op     (alu_op),
    .control    (control),
    .busy       (busy),
    .halted     (halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  // Reference model: instruction-level view. mode 0 idle, 1 waiting for fetch,
  // 2 draining the per-instruction strobe list, 3 halted. Conditional jumps are
  // kept symbolic (-1 JZ, -2 JC) and resolved against the flags of their cycle.
  int m_mode = 0;
  int m_pc = 0;
  logic [7:0] m_ir = '0;
  int mq[$];
  int m_c;
  bit started = 0;
  function automatic int exec_code(input logic [3:0] op);
    case (op)
      4'h1: return 32'h8;
      4'h2: return 32'h10;
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: return 1 << (int'(op) + 4);
      4'h9: return 32'h40;
      4'hA: return 32'h4;
      4'hB: return -1;
      4'hC: return -2;
      4'hF: return 32'h4000;
      default: return 0;
    endcase
  endfunction
  function automatic int resolve(input int c);
    return c == -1 ? (zero_flag ? 4 : 0) : c == -2 ? (carry_flag ? 4 : 0) : c;
  endfunction
  function automatic int exp_ctl();
    if (!reset) return 0;
    if (m_mode == 1) return instr_valid ? 1 : 0;
    if (m_mode == 2) return resolve(mq[0]);
    return 0;
  endfunction
  always @(posedge clk) begin
    if (!reset) begin
      started = 1;
      m_mode = 0;
      m_pc = 0;
      m_ir = '0;
      mq.delete();
    end else if (m_mode == 0) begin
      if (run) m_mode = 1;
    end else if (m_mode == 1) begin
      if (instr_valid) begin
        m_ir = instr;
        mq.delete();
        mq.push_back(2);
        mq.push_back(exec_code(instr[7:4]));
        if (instr[7:4] >= 4'h3 && instr[7:4] <= 4'h8) mq.push_back(32'h20);
        m_mode = 2;
      end
    end else if (m_mode == 2) begin
      m_c = resolve(mq[0]);
      void'(mq.pop_front());
      if (m_c == 2) m_pc = (m_pc + 1) % 16;
      if (m_c == 4) m_pc = int'(m_ir[3:0]);
      if (m_c == 32'h4000) m_mode = 3;
      else if (mq.size() == 0) m_mode = run ? 1 : 0;
    end
  end
  always @(negedge clk)
    if (started) begin
      chk("m_control", control, exp_ctl());
      chk("m_fetch_req", fetch_req, (reset && m_mode == 1) ? 1 : 0);
      chk("m_pc", pc, m_pc);
      chk("m_operand", operand, m_ir[3:0]);
      chk("m_alu_op", alu_op, m_ir[7:4]);
      chk("m_busy", busy, (m_mode == 1 || m_mode == 2) ? 1 : 0);
      chk("m_halted", halted, m_mode == 3 ? 1 : 0);
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic look(input string n, input int unsigned e);
    @(negedge clk);
    chk(n, control, e);
    cyc();
  endtask
  initial begin
    cyc();
    cyc();
    reset = 1'b1;
    run = 1'b1;
    look("rst_idle", 0);
    @(negedge clk);
    chk("rst_fetch_req_hi", fetch_req, 1);
    cyc();
    reset = 1'b0;
    instr_valid = 1'b1;
    instr = 8'h15;
    @(negedge clk);
    chk("rst_fetch_req_masked", fetch_req, 0);
    chk("rst_control_masked", control, 0);
    cyc();
    reset = 1'b1;
    run = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pc, 0);
    chk("rst_control", control, 0);
    chk("rst_operand", operand, 0);
    cyc();
    run = 1'b1;
    look("lda_idle", 0);
    instr_valid = 1'b1;
    instr = 8'h15;
    look("lda_ir_load", 16'h0001);
    instr_valid = 1'b0;
    run = 1'b0;
    look("lda_pc_inc", 16'h0002);
    look("lda_a_load", 16'h0008);
    @(negedge clk);
    chk("lda_operand", operand, 5);
    chk("lda_pc", pc, 1);
    cyc();
    run = 1'b1;
    look("add_idle", 0);
    look("add_wait1", 0);
    look("add_wait2", 0);
    instr_valid = 1'b1;
    instr = 8'h30;
    look("add_ir_load", 16'h0001);
    instr_valid = 1'b0;
    look("add_pc_inc", 16'h0002);
    look("add_alu", 16'h0080);
    run = 1'b0;
    look("add_acc", 16'h0020);
    @(negedge clk);
    chk("add_alu_op", alu_op, 3);
    chk("add_busy_after", busy, 0);
    cyc();
    run = 1'b1;
    look("jz1_idle", 0);
    instr_valid = 1'b1;
    instr = 8'hBC;
    look("jz1_ir_load", 16'h0001);
    instr_valid = 1'b0;
    look("jz1_pc_inc", 16'h0002);
    zero_flag = 1'b1;
    run = 1'b0;
    look("jz1_taken", 16'h0004);
    zero_flag = 1'b0;
    @(negedge clk);
    chk("jz1_pc", pc, 4'hC);
    cyc();
    run = 1'b1;
    look("jz0_idle", 0);
    instr_valid = 1'b1;
    instr = 8'hBC;
    look("jz0_ir_load", 16'h0001);
    instr_valid = 1'b0;
    look("jz0_pc_inc", 16'h0002);
    run = 1'b0;
    look("jz0_not_taken", 0);
    @(negedge clk);
    chk("jz0_pc", pc, 4'hD);
    cyc();
    run = 1'b1;
    look("jmp_idle", 0);
    instr_valid = 1'b1;
    instr = 8'hAF;
    look("jmp_ir_load", 16'h0001);
    instr_valid = 1'b0;
    look("jmp_pc_inc", 16'h0002);
    run = 1'b0;
    look("jmp_load", 16'h0004);
    @(negedge clk);
    chk("jmp_pc", pc, 4'hF);
    cyc();
    run = 1'b1;
    look("nop_idle", 0);
    instr_valid = 1'b1;
    instr = 8'h00;
    look("nop_ir_load", 16'h0001);
    instr_valid = 1'b0;
    run = 1'b0;
    look("nop_pc_inc", 16'h0002);
    @(negedge clk);
    chk("nop_pc_wrap", pc, 0);
    chk("nop_exec", control, 0);
    cyc();
    run = 1'b1;
    look("hlt_idle", 0);
    instr_valid = 1'b1;
    instr = 8'hF0;
    look("hlt_ir_load", 16'h0001);
    instr_valid = 1'b0;
    look("hlt_pc_inc", 16'h0002);
    look("hlt_strobe", 16'h4000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hlt_halted", halted, 1);
      chk("hlt_control", control, 0);
      chk("hlt_busy", busy, 0);
      cyc();
    end
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    run = 1'b0;
    @(negedge clk);
    chk("hlt_reset_clears", halted, 0);
    cyc();
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 59) != 0;
      run = $urandom_range(0, 3) != 0;
      instr_valid = $urandom_range(0, 2) == 0;
      instr = 8'($urandom);
      if (instr[7:4] == 4'hF && $urandom_range(0, 3) != 0) instr[7:4] = 4'h3;
      zero_flag = 1'($urandom);
      carry_flag = 1'($urandom);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
